// File: rtl/crc5_checker.sv
// Serial CRC-5 checker: divides each received codeword by x^5+x^4+x^2+1 and reports
// the remainder, pass/fail and completion of every frame.
module crc5_checker #(
  parameter int unsigned DATA_LEN = 11
) (
  input  logic       ckclck,
  input  logic       cknrst,
  input  logic       ckin,
  input  logic       ckvalid,
  input  logic       ckstart,
  output logic       ckbusy,
  output logic       ckdone,
  output logic       ckok,
  output logic       ckerr,
  output logic [4:0] cksyn
);

  localparam int unsigned FrameLen = DATA_LEN + 5;
  localparam int unsigned CntW     = $clog2(DATA_LEN + 6);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e            state_q;
  logic [4:0]        r_q;
  logic [CntW-1:0]   cnt_q;
  logic [4:0]        r_step;
  logic [CntW-1:0]   cnt_inc;
  logic              last_bit;

  always_comb begin
    r_step   = {r_q[3] ^ r_q[4], r_q[2], r_q[1] ^ r_q[4], r_q[0], ckin ^ r_q[4]};
    cnt_inc  = cnt_q + CntW'(1);
    last_bit = (cnt_inc == CntW'(FrameLen));
  end

  // Results are latched on the edge that accepts the final bit so they are visible
  // during the DONE cycle together with ckdone.
  always_ff @(posedge ckclck or negedge cknrst) begin
    if (!cknrst) begin
      state_q <= StIdle;
      r_q     <= 5'b0;
      cnt_q   <= '0;
      ckbusy  <= 1'b0;
      ckdone  <= 1'b0;
      ckok    <= 1'b0;
      ckerr   <= 1'b0;
      cksyn   <= 5'b0;
    end else begin
      ckdone <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ckvalid && ckstart) begin
            r_q     <= {4'b0, ckin};
            cnt_q   <= CntW'(1);
            state_q <= StRecv;
            ckbusy  <= 1'b1;
          end
        end
        StRecv: begin
          if (ckvalid) begin
            if (ckstart) begin
              r_q   <= {4'b0, ckin};
              cnt_q <= CntW'(1);
            end else begin
              r_q   <= r_step;
              cnt_q <= cnt_inc;
              if (last_bit) begin
                state_q <= StDone;
                ckdone  <= 1'b1;
                cksyn   <= r_step;
                ckok    <= (r_step == 5'b0);
                ckerr   <= (r_step != 5'b0);
              end
            end
          end
        end
        StDone: begin
          // A start bit here begins the next frame without a gap.
          if (ckvalid && ckstart) begin
            r_q     <= {4'b0, ckin};
            cnt_q   <= CntW'(1);
            state_q <= StRecv;
          end else begin
            cnt_q   <= '0;
            state_q <= StIdle;
            ckbusy  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          ckbusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/crc5_checker.md
CRC5_CHECKER -- requirements
Module: crc5_checker

Interface
REQ-001 Parameter DATA_LEN, default 11, number of data bits per frame (legal range 1..250); the frame length is DATA_LEN+5 bits.
REQ-002 ckclck  input  1  sole clock; all state updates on the rising edge.
REQ-003 cknrst  input  1  reset, asynchronous, active-low.
REQ-004 ckin  input  1  serial codeword bit, most significant (first transmitted) bit first.
REQ-005 ckvalid  input  1  qualifies ckin; a bit is accepted only on an edge where ckvalid=1.
REQ-006 ckstart  input  1  marks the accepted bit as the first bit of a new frame; meaningful only with ckvalid=1.
REQ-007 ckbusy  output  1  high while a frame is in progress.
REQ-008 ckdone  output  1  single-cycle pulse when a frame completes.
REQ-009 ckok  output  1  last completed frame had zero syndrome.
REQ-010 ckerr  output  1  last completed frame had nonzero syndrome.
REQ-011 cksyn  output  5  remainder of the last completed frame; bit i is the coefficient of x^i.

Function
REQ-012 The block SHALL divide the received codeword by g(x)=x^5+x^4+x^2+1, using a 5-bit Galois register r[4:0] updated per accepted bit: r0<=ckin^r4, r1<=r0, r2<=r1^r4, r3<=r2, r4<=r3^r4.
REQ-013 A valid codeword is any DATA_LEN+5-bit polynomial divisible by g(x); the syndrome is r after the final bit.
REQ-014 FSM states: IDLE, RECV, DONE.
REQ-015 IDLE: ckvalid=1 with ckstart=1 -> r loads {4'b0, ckin} (bit processed from a cleared register), bit count=1, go to RECV; ckvalid=1 with ckstart=0 -> bit discarded, stay IDLE.
REQ-016 RECV: ckvalid=0 -> hold r and count (stall, unbounded length); ckvalid=1, ckstart=0 -> step r, increment count.
REQ-017 RECV: when the accepted bit makes count equal DATA_LEN+5, go to DONE.
REQ-018 DONE (one cycle): ckdone=1; cksyn<=r; ckok<=(r==0); ckerr<=(r!=0); then go to IDLE.
REQ-019 Latency: ckdone SHALL assert on the cycle immediately after the edge that accepted the final bit; cksyn/ckok/ckerr SHALL be valid in that same cycle.
REQ-020 cksyn, ckok, ckerr SHALL hold their values until the next DONE or reset; ckok and ckerr SHALL never both be 1.
REQ-021 ckbusy SHALL be 1 in RECV and DONE, 0 in IDLE.
REQ-022 ckstart=1 with ckvalid=1 while in RECV SHALL abort the current frame without ckdone and restart as in REQ-015 on that bit.
REQ-023 ckstart=1 with ckvalid=1 while in DONE SHALL start a new frame (REQ-015) while DONE completes normally (back-to-back frames, no lost bit); other accepted bits in DONE are discarded.
REQ-024 ckstart with ckvalid=0 SHALL be ignored in every state.
REQ-025 The bit counter SHALL be sized ceil(log2(DATA_LEN+6)) bits and SHALL not wrap within a frame.

Reset
REQ-026 cknrst=0 SHALL immediately, without a clock, force state IDLE, r=0, count=0, ckbusy=0, ckdone=0, ckok=0, ckerr=0, cksyn=5'b00000.
REQ-027 Reset asserted mid-frame SHALL discard the frame with no ckdone; the first frame after release requires a fresh ckstart.
REQ-028 Reset release SHALL take effect at the first rising edge of ckclck after cknrst returns high.

Verification
REQ-029 DATA_LEN=11, frame 0000000000110101 (ckstart on first bit, ckvalid continuous) -> ckdone 1 cycle after 16th bit, ckok=1, ckerr=0, cksyn=00000.
REQ-030 Same frame with last bit flipped (...110100) -> ckerr=1, ckok=0, cksyn=00001; flip second-to-last bit (...110111) -> cksyn=00010.
REQ-031 Frame of REQ-029 with ckvalid=0 inserted for 3 cycles after bits 4 and 12 -> identical result, ckdone 1 cycle after last accepted bit, ckbusy=1 throughout.
REQ-032 Two frames back-to-back (REQ-029 then REQ-030 last-bit-flip), second ckstart on the DONE cycle -> two ckdone pulses 16 cycles apart, results 00000/ok then 00001/err.
REQ-033 cknrst=0 after 7 bits of a frame -> all outputs 0 asynchronously; no ckdone; subsequent REQ-029 frame -> ckok=1.
REQ-034 ckstart re-asserted at bit 9 of a frame, followed by a full REQ-029 frame -> exactly one ckdone, ckok=1.
